dds_tw_bank: RTL and testbench

Multi-channel, double-buffered tuning-word register bank for the DDS datapath. It is the parametrised successor of the single enable/clear register. A narrow host bus loads each channel's word over several beats into per-channel shadow registers. One commit strobe then transfers every pending shadow word to the active outputs in the same edge, so all phase accumulators retune together without glitches.

---
 rtl/dds_pkg.sv | 11 +
 rtl/dds_tw_slot.sv | 41 ++++
 rtl/dds_tw_bank.sv | 151 +++++++++++++++
 tb/tb_dds_tw_bank.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dds_pkg.sv
// Shared types and helpers for the DDS tuning-word register bank.
package dds_pkg;

   typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_COMMIT} dds_tw_state_t;

   // Index width that never collapses to zero bits for single-entry ranges.
   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/dds_tw_slot.sv
// One channel of the bank: shadow word, active word and pending flag.
module dds_tw_slot #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rsth,
   input  logic                  clrh,
   input  logic                  load,
   input  logic [DATA_WIDTH-1:0] load_data,
   input  logic                  commit,
   output logic [DATA_WIDTH-1:0] active,
   output logic                  pending
);

   logic [DATA_WIDTH-1:0] shadow;

   // A load on the commit edge lands after the transfer, so it stays pending.
   always_ff @(posedge clk or posedge rsth) begin
      if (rsth) begin
         shadow  <= '0;
         active  <= '0;
         pending <= 1'b0;
      end else if (clrh) begin
         shadow  <= '0;
         active  <= '0;
         pending <= 1'b0;
      end else begin
         if (commit) begin
            if (pending) begin
               active <= shadow;
            end
            pending <= 1'b0;
         end
         if (load) begin
            shadow  <= load_data;
            pending <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/dds_tw_bank.sv
// Double-buffered tuning-word bank: multi-beat host loads into shadows, one
// commit strobe retunes every pending channel on the same edge.
module dds_tw_bank
   import dds_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int BUS_WIDTH  = 8,
   parameter int NUM_CH     = 4,
   localparam int CH_W      = clog2_min1(NUM_CH)
) (
   input  logic                         clk,
   input  logic                         rsth,
   input  logic                         clrh,
   input  logic                         wr_valid,
   output logic                         wr_ready,
   input  logic [CH_W-1:0]              wr_ch,
   input  logic [BUS_WIDTH-1:0]         wr_data,
   input  logic                         abort_h,
   input  logic                         commit_h,
   output logic [NUM_CH*DATA_WIDTH-1:0] tw_out,
   output logic [NUM_CH-1:0]            pending,
   output logic                         commit_done
);

   localparam int BEATS = DATA_WIDTH / BUS_WIDTH;
   localparam int CNT_W = clog2_min1(BEATS);
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

   if ((DATA_WIDTH % BUS_WIDTH) != 0) begin : g_width_check
      $error("dds_tw_bank: DATA_WIDTH must be a multiple of BUS_WIDTH");
   end
   if (NUM_CH < 1) begin : g_ch_check
      $error("dds_tw_bank: NUM_CH must be at least 1");
   end

   dds_tw_state_t         state, next_state;
   logic [CNT_W-1:0]      cnt, cnt_n;
   logic [DATA_WIDTH-1:0] asm_q, asm_n, word;
   logic [CH_W-1:0]       ch_lat, ch_n, load_ch;
   logic                  commit_req, req_n;
   logic                  load_en, do_commit, beat;

   assign beat = wr_valid && wr_ready;

   // Current assembly with this cycle's beat merged into its slot.
   always_comb begin
      word = (state == ST_IDLE) ? '0 : asm_q;
      word[cnt*BUS_WIDTH +: BUS_WIDTH] = wr_data;
   end

   always_comb begin
      next_state = state;
      cnt_n      = cnt;
      asm_n      = asm_q;
      ch_n       = ch_lat;
      req_n      = commit_req;
      load_en    = 1'b0;
      load_ch    = ch_lat;
      do_commit  = 1'b0;
      case (state)
         ST_IDLE: begin
            req_n = 1'b0;
            if (commit_h) begin
               do_commit = 1'b1;
            end
            if (beat) begin
               if (BEATS == 1) begin
                  load_en = 1'b1;
                  load_ch = wr_ch;
               end else begin
                  next_state = ST_LOAD;
                  cnt_n      = CNT_W'(1);
                  asm_n      = word;
                  ch_n       = wr_ch;
               end
            end
         end
         ST_LOAD: begin
            if (commit_h) begin
               req_n = 1'b1;
            end
            if (abort_h) begin
               asm_n      = '0;
               cnt_n      = '0;
               next_state = (commit_req || commit_h) ? ST_COMMIT : ST_IDLE;
            end else if (beat) begin
               if (cnt == LAST_BEAT) begin
                  load_en    = 1'b1;
                  asm_n      = '0;
                  cnt_n      = '0;
                  next_state = (commit_req || commit_h) ? ST_COMMIT : ST_IDLE;
               end else begin
                  asm_n = word;
                  cnt_n = cnt + 1'b1;
               end
            end
         end
         ST_COMMIT: begin
            do_commit  = 1'b1;
            req_n      = 1'b0;
            next_state = ST_IDLE;
         end
         default: begin
            next_state = ST_IDLE;
         end
      endcase
   end

   // wr_ready tracks the next state so it is low exactly while in COMMIT.
   always_ff @(posedge clk or posedge rsth) begin
      if (rsth) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         asm_q       <= '0;
         ch_lat      <= '0;
         commit_req  <= 1'b0;
         commit_done <= 1'b0;
         wr_ready    <= 1'b1;
      end else if (clrh) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         asm_q       <= '0;
         ch_lat      <= '0;
         commit_req  <= 1'b0;
         commit_done <= 1'b0;
         wr_ready    <= 1'b1;
      end else begin
         state       <= next_state;
         cnt         <= cnt_n;
         asm_q       <= asm_n;
         ch_lat      <= ch_n;
         commit_req  <= req_n;
         commit_done <= do_commit;
         wr_ready    <= (next_state != ST_COMMIT);
      end
   end

   for (genvar c = 0; c < NUM_CH; c++) begin : g_slot
      dds_tw_slot #(.DATA_WIDTH(DATA_WIDTH)) u_slot (
         .clk       (clk),
         .rsth      (rsth),
         .clrh      (clrh),
         .load      (load_en && (load_ch == CH_W'(c))),
         .load_data (word),
         .commit    (do_commit),
         .active    (tw_out[c*DATA_WIDTH +: DATA_WIDTH]),
         .pending   (pending[c])
      );
   end

endmodule

// File: tb/tb_dds_tw_bank.sv
// Self-checking bench for dds_tw_bank: directed scenarios plus randomized loads
// against a per-channel shadow/active/pending reference model.
module tb_dds_tw_bank;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rsth, clrh;
   logic         wr_valid, wr_ready, abort_h, commit_h, commit_done;
   logic [1:0]   wr_ch;
   logic [7:0]   wr_data;
   logic [127:0] tw_out;
   logic [3:0]   pending;

   logic         b_wr_valid, b_wr_ready, b_abort_h, b_commit_h, b_commit_done;
   logic [1:0]   b_wr_ch;
   logic [31:0]  b_wr_data;
   logic [127:0] b_tw_out;
   logic [3:0]   b_pending;

   int total = 0;
   int bad   = 0;

   logic [31:0] m_shadow [4];
   logic [31:0] m_active [4];
   logic [3:0]  m_pend;

   dds_tw_bank #(.DATA_WIDTH(32), .BUS_WIDTH(8), .NUM_CH(4)) dut (
      .clk(clk), .rsth(rsth), .clrh(clrh), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .wr_ch(wr_ch), .wr_data(wr_data), .abort_h(abort_h), .commit_h(commit_h),
      .tw_out(tw_out), .pending(pending), .commit_done(commit_done)
   );

   dds_tw_bank #(.DATA_WIDTH(32), .BUS_WIDTH(32), .NUM_CH(4)) dut32 (
      .clk(clk), .rsth(rsth), .clrh(clrh), .wr_valid(b_wr_valid), .wr_ready(b_wr_ready),
      .wr_ch(b_wr_ch), .wr_data(b_wr_data), .abort_h(b_abort_h), .commit_h(b_commit_h),
      .tw_out(b_tw_out), .pending(b_pending), .commit_done(b_commit_done)
   );

   function automatic logic [127:0] exp_tw();
      return {m_active[3], m_active[2], m_active[1], m_active[0]};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         m_shadow[i] = '0;
         m_active[i] = '0;
      end
      m_pend = '0;
   endtask

   task automatic model_load(input int ch, input logic [31:0] w);
      m_shadow[ch] = w;
      m_pend[ch]   = 1'b1;
   endtask

   task automatic model_commit();
      for (int i = 0; i < 4; i++) begin
         if (m_pend[i]) m_active[i] = m_shadow[i];
      end
      m_pend = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_beat(input int ch, input logic [7:0] d);
      wr_valid = 1'b1;
      wr_ch    = 2'(ch);
      wr_data  = d;
      tick();
      wr_valid = 1'b0;
   endtask

   task automatic send_word(input int ch, input logic [31:0] w);
      for (int b = 0; b < 4; b++) send_beat(ch, w[b*8 +: 8]);
   endtask

   task automatic pulse_commit();
      commit_h = 1'b1;
      tick();
      commit_h = 1'b0;
   endtask

   task automatic test_reset();
      rsth = 1'b1;
      tick();
      model_reset();
      total++; if (tw_out !== 128'h0) begin bad++; $display("[TB] FAIL reset_tw got=%h exp=0", tw_out); end
      total++; if (pending !== 4'h0) begin bad++; $display("[TB] FAIL reset_pending got=%b exp=0000", pending); end
      total++; if (commit_done !== 1'b0) begin bad++; $display("[TB] FAIL reset_done got=%b exp=0", commit_done); end
      total++; if (wr_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_ready got=%b exp=1", wr_ready); end
      rsth = 1'b0;
      tick();
   endtask

   task automatic test_single_load();
      logic [31:0] w;
      w = 32'h12345678;
      for (int b = 0; b < 3; b++) begin
         send_beat(2, w[b*8 +: 8]);
         total++; if (pending !== 4'b0000) begin bad++; $display("[TB] FAIL partial_pending beat=%0d got=%b exp=0000", b, pending); end
      end
      send_beat(2, w[31:24]);
      model_load(2, w);
      total++; if (pending !== 4'b0100) begin bad++; $display("[TB] FAIL load_pending got=%b exp=0100", pending); end
      total++; if (tw_out !== exp_tw()) begin bad++; $display("[TB] FAIL load_tw_held got=%h exp=%h", tw_out, exp_tw()); end
      pulse_commit();
      model_commit();
      total++; if (tw_out[64 +: 32] !== 32'h12345678) begin bad++; $display("[TB] FAIL commit_ch2 got=%h exp=12345678", tw_out[64 +: 32]); end
      total++; if (pending !== 4'b0000) begin bad++; $display("[TB] FAIL commit_pending got=%b exp=0000", pending); end
      total++; if (commit_done !== 1'b1) begin bad++; $display("[TB] FAIL commit_done_hi got=%b exp=1", commit_done); end
      tick();
      total++; if (commit_done !== 1'b0) begin bad++; $display("[TB] FAIL commit_done_pulse got=%b exp=0", commit_done); end
   endtask

   task automatic test_two_channels();
      send_word(0, 32'hAAAA0001);
      model_load(0, 32'hAAAA0001);
      send_word(3, 32'h0000BEEF);
      model_load(3, 32'h0000BEEF);
      total++; if (pending !== 4'b1001) begin bad++; $display("[TB] FAIL two_pending got=%b exp=1001", pending); end
      total++; if (tw_out !== exp_tw()) begin bad++; $display("[TB] FAIL two_tw_held got=%h exp=%h", tw_out, exp_tw()); end
      pulse_commit();
      model_commit();
      total++; if (tw_out !== exp_tw()) begin bad++; $display("[TB] FAIL two_commit got=%h exp=%h", tw_out, exp_tw()); end
      total++; if (tw_out[32 +: 32] !== 32'h0) begin bad++; $display("[TB] FAIL two_ch1_zero got=%h exp=0", tw_out[32 +: 32]); end
      tick();
   endtask

   task automatic test_deferred_commit();
      logic [31:0] w;
      w = 32'hCAFEF00D;
      for (int b = 0; b < 4; b++) begin
         commit_h = (b == 1);
         send_beat(1, w[b*8 +: 8]);
         commit_h = 1'b0;
      end
      model_load(1, w);
      total++; if (wr_ready !== 1'b0) begin bad++; $display("[TB] FAIL defer_ready_low got=%b exp=0", wr_ready); end
      total++; if (tw_out !== exp_tw()) begin bad++; $display("[TB] FAIL defer_tw_held got=%h exp=%h", tw_out, exp_tw()); end
      total++; if (pending !== m_pend) begin bad++; $display("[TB] FAIL defer_pending got=%b exp=%b", pending, m_pend); end
      tick();
      model_commit();
      total++; if (tw_out[32 +: 32] !== 32'hCAFEF00D) begin bad++; $display("[TB] FAIL defer_ch1 got=%h exp=cafef00d", tw_out[32 +: 32]); end
      total++; if (wr_ready !== 1'b1) begin bad++; $display("[TB] FAIL defer_ready_back got=%b exp=1", wr_ready); end
      total++; if (commit_done !== 1'b1) begin bad++; $display("[TB] FAIL defer_done got=%b exp=1", commit_done); end
      total++; if (pending !== 4'b0000) begin bad++; $display("[TB] FAIL defer_pending_clr got=%b exp=0000", pending); end
      tick();
   endtask

   task automatic test_abort();
      send_word(0, 32'h11111111);
      model_load(0, 32'h11111111);
      send_beat(0, 8'h22);
      send_beat(0, 8'h33);
      abort_h = 1'b1;
      wr_valid = 1'b1;
      wr_data  = 8'h44;
      tick();
      abort_h = 1'b0;
      wr_valid = 1'b0;
      total++; if (pending !== 4'b0001) begin bad++; $display("[TB] FAIL abort_pending got=%b exp=0001", pending); end
      pulse_commit();
      model_commit();
      total++; if (tw_out[0 +: 32] !== 32'h11111111) begin bad++; $display("[TB] FAIL abort_ch0 got=%h exp=11111111", tw_out[0 +: 32]); end
      send_word(2, 32'h0A0B0C0D);
      model_load(2, 32'h0A0B0C0D);
      pulse_commit();
      model_commit();
      total++; if (tw_out !== exp_tw()) begin bad++; $display("[TB] FAIL after_abort_tw got=%h exp=%h", tw_out, exp_tw()); end
   endtask

   task automatic test_reset_midload();
      send_beat(3, 8'h99);
      send_beat(3, 8'h88);
      rsth = 1'b1;
      #1;
      model_reset();
      total++; if (tw_out !== 128'h0) begin bad++; $display("[TB] FAIL rst_mid_tw got=%h exp=0", tw_out); end
      total++; if (pending !== 4'h0) begin bad++; $display("[TB] FAIL rst_mid_pending got=%b exp=0000", pending); end
      total++; if (wr_ready !== 1'b1 || commit_done !== 1'b0) begin bad++; $display("[TB] FAIL rst_mid_ctrl got=%b%b exp=10", wr_ready, commit_done); end
      tick();
      rsth = 1'b0;
      tick();
      send_word(3, 32'h76543210);
      model_load(3, 32'h76543210);
      pulse_commit();
      model_commit();
      total++; if (tw_out !== exp_tw()) begin bad++; $display("[TB] FAIL rst_reload_tw got=%h exp=%h", tw_out, exp_tw()); end
   endtask

   task automatic test_clear();
      send_word(1, 32'h5A5A5A5A);
      model_load(1, 32'h5A5A5A5A);
      clrh = 1'b1;
      commit_h = 1'b1;
      tick();
      clrh = 1'b0;
      commit_h = 1'b0;
      model_reset();
      total++; if (tw_out !== 128'h0) begin bad++; $display("[TB] FAIL clr_tw got=%h exp=0", tw_out); end
      total++; if (pending !== 4'h0) begin bad++; $display("[TB] FAIL clr_pending got=%b exp=0000", pending); end
      total++; if (commit_done !== 1'b0) begin bad++; $display("[TB] FAIL clr_done got=%b exp=0", commit_done); end
      total++; if (wr_ready !== 1'b1) begin bad++; $display("[TB] FAIL clr_ready got=%b exp=1", wr_ready); end
      tick();
      total++; if (commit_done !== 1'b0) begin bad++; $display("[TB] FAIL clr_done_late got=%b exp=0", commit_done); end
   endtask

   task automatic test_random();
      for (int it = 0; it < 40; it++) begin
         int ch, mode, k;
         logic [31:0] w;
         ch   = $urandom_range(0, 3);
         mode = $urandom_range(0, 3);
         k    = $urandom_range(1, 3);
         w    = $urandom;
         if (mode == 3) begin
            send_beat(ch, w[7:0]);
            send_beat(ch, w[15:8]);
            abort_h = 1'b1;
            tick();
            abort_h = 1'b0;
         end else begin
            for (int b = 0; b < 4; b++) begin
               commit_h = (mode == 1 && b == k);
               send_beat(ch, w[b*8 +: 8]);
               commit_h = 1'b0;
            end
            model_load(ch, w);
            if (mode == 1) begin
               total++; if (wr_ready !== 1'b0) begin bad++; $display("[TB] FAIL rnd_ready it=%0d got=%b exp=0", it, wr_ready); end
               tick();
               model_commit();
               total++; if (commit_done !== 1'b1) begin bad++; $display("[TB] FAIL rnd_defer_done it=%0d got=%b exp=1", it, commit_done); end
            end else if (mode == 2) begin
               pulse_commit();
               model_commit();
            end
         end
         total++; if (tw_out !== exp_tw()) begin bad++; $display("[TB] FAIL rnd_tw it=%0d got=%h exp=%h", it, tw_out, exp_tw()); end
         total++; if (pending !== m_pend) begin bad++; $display("[TB] FAIL rnd_pending it=%0d got=%b exp=%b", it, pending, m_pend); end
      end
   endtask

   task automatic test_bus32();
      b_wr_valid = 1'b1;
      b_wr_ch    = 2'd0;
      b_wr_data  = 32'hDEAD0000;
      tick();
      total++; if (b_pending !== 4'b0001) begin bad++; $display("[TB] FAIL b32_first_pending got=%b exp=0001", b_pending); end
      total++; if (b_wr_ready !== 1'b1) begin bad++; $display("[TB] FAIL b32_ready got=%b exp=1", b_wr_ready); end
      b_wr_ch    = 2'd1;
      b_wr_data  = 32'h00000100;
      b_commit_h = 1'b1;
      tick();
      b_wr_valid = 1'b0;
      b_commit_h = 1'b0;
      total++; if (b_commit_done !== 1'b1) begin bad++; $display("[TB] FAIL b32_done got=%b exp=1", b_commit_done); end
      total++; if (b_tw_out[32 +: 32] !== 32'h0) begin bad++; $display("[TB] FAIL b32_ch1 got=%h exp=0", b_tw_out[32 +: 32]); end
      total++; if (b_tw_out[0 +: 32] !== 32'hDEAD0000) begin bad++; $display("[TB] FAIL b32_ch0 got=%h exp=dead0000", b_tw_out[0 +: 32]); end
      total++; if (b_pending !== 4'b0010) begin bad++; $display("[TB] FAIL b32_pending got=%b exp=0010", b_pending); end
      b_commit_h = 1'b1;
      tick();
      b_commit_h = 1'b0;
      total++; if (b_tw_out[32 +: 32] !== 32'h00000100) begin bad++; $display("[TB] FAIL b32_ch1_commit got=%h exp=00000100", b_tw_out[32 +: 32]); end
   endtask

   initial begin
      rsth = 1'b0; clrh = 1'b0;
      wr_valid = 1'b0; wr_ch = '0; wr_data = '0; abort_h = 1'b0; commit_h = 1'b0;
      b_wr_valid = 1'b0; b_wr_ch = '0; b_wr_data = '0; b_abort_h = 1'b0; b_commit_h = 1'b0;
      model_reset();
      test_reset();
      test_single_load();
      test_two_channels();
      test_deferred_commit();
      test_abort();
      test_reset_midload();
      test_clear();
      test_random();
      test_bus32();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
